// File: rtl/miriscv_comdecode_pkg.sv
// Shared decode types for the miriscv core: memory command encoding,
// LSU access size, LSU sequencer states and the command -> LSU mapping.
package miriscv_comdecode_pkg;

  localparam int LSU_BE_W = 4;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } lsu_state_t;

  typedef enum logic [3:0] {
    CMD_NOP,
    LOAD_BYTE,
    LOAD_HALF,
    LOAD_WORD,
    LOAD_BYTE_UNSIGN,
    LOAD_HALF_UNSIGN,
    STORE_BYTE,
    STORE_HALF,
    STORE_WORD
  } command_t;

  typedef struct packed {
    logic      we;
    lsu_size_t size;
    logic      uns;
  } lsu_cmd_t;

  // Map a decoded memory command onto the LSU control fields.
  // Non-memory commands decode to a harmless signed word load.
  function automatic lsu_cmd_t lsu_cmd_decode(command_t cmd);
    lsu_cmd_t c;
    c = '{we: 1'b0, size: LSU_WORD, uns: 1'b0};
    case (cmd)
      LOAD_BYTE:        c = '{we: 1'b0, size: LSU_BYTE, uns: 1'b0};
      LOAD_HALF:        c = '{we: 1'b0, size: LSU_HALF, uns: 1'b0};
      LOAD_WORD:        c = '{we: 1'b0, size: LSU_WORD, uns: 1'b0};
      LOAD_BYTE_UNSIGN: c = '{we: 1'b0, size: LSU_BYTE, uns: 1'b1};
      LOAD_HALF_UNSIGN: c = '{we: 1'b0, size: LSU_HALF, uns: 1'b1};
      STORE_BYTE:       c = '{we: 1'b1, size: LSU_BYTE, uns: 1'b0};
      STORE_HALF:       c = '{we: 1'b1, size: LSU_HALF, uns: 1'b0};
      STORE_WORD:       c = '{we: 1'b1, size: LSU_WORD, uns: 1'b0};
      default:          c = '{we: 1'b0, size: LSU_WORD, uns: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/miriscv_lsu_ctrl_if.sv
// Data-memory request/grant/response bus between the LSU and memory.
interface miriscv_lsu_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              data_req_o;
  logic              data_we_o;
  logic [3:0]        data_be_o;
  logic [ADDR_W-1:0] data_addr_o;
  logic [DATA_W-1:0] data_wdata_o;
  logic              data_gnt_i;
  logic              data_rvalid_i;
  logic [DATA_W-1:0] data_rdata_i;

  // LSU side drives the request, memory answers with grant/response.
  modport master (
    output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i
  );
endinterface

// File: rtl/miriscv_lsu_fmt.sv
// Combinational data formatting for the LSU: byte enables, store lane
// replication and load lane select with sign/zero extension.
module miriscv_lsu_fmt
  import miriscv_comdecode_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  lsu_size_t                size,
  input  logic                     uns,
  input  logic [1:0]               addr_lo,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W-1:0]        rdata,
  output logic [LSU_BE_W-1:0]      be,
  output logic [DATA_W-1:0]        wdata_rep,
  output logic [DATA_W-1:0]        rdata_ext
);
  localparam int NUM_LANES = DATA_W / 8;

  logic [NUM_LANES-1:0][7:0] lanes;
  logic [DATA_W-1:0]         b_sh;
  logic [DATA_W-1:0]         h_sh;

  // Byte enables; a misaligned half falls back to the half selected by addr[1].
  always_comb begin
    be = 4'b1111;
    case (size)
      LSU_BYTE: be = 4'b0001 << addr_lo;
      LSU_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
      default:  be = 4'b1111;
    endcase
  end

  // Store data is replicated onto every lane so memory picks it via be.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign lanes[l] = (size == LSU_BYTE) ? wdata[7:0] :
                      (size == LSU_HALF) ? wdata[8*(l%2) +: 8] :
                                           wdata[8*l +: 8];
  end
  assign wdata_rep = lanes;

  assign b_sh = rdata >> {addr_lo, 3'b000};
  assign h_sh = rdata >> {addr_lo[1], 4'b0000};

  // Right-align the addressed lane(s) and extend to full width.
  always_comb begin
    rdata_ext = rdata;
    case (size)
      LSU_BYTE: rdata_ext = {{(DATA_W-8){~uns & b_sh[7]}}, b_sh[7:0]};
      LSU_HALF: rdata_ext = {{(DATA_W-16){~uns & h_sh[15]}}, h_sh[15:0]};
      default:  rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu_ctrl.sv
// Load/store sequencer: latches one memory command from execute, runs the
// req/gnt/rvalid handshake, stalls the core until done and formats data.
// Optional feature macro: MIRISCV_LSU_MISALIGN_TRAP_EN (misaligned half/word
// accesses skip the bus and complete with lsu_misalign_o).
module miriscv_lsu_ctrl
  import miriscv_comdecode_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [1:0]        lsu_size_i,
  input  logic              lsu_unsigned_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  input  logic              lsu_kill_i,
  output logic              lsu_stall_o,
  output logic              lsu_done_o,
  output logic [DATA_W-1:0] lsu_rdata_o,
`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
  output logic              lsu_misalign_o,
`endif
  miriscv_lsu_ctrl_if.master bus
);

  lsu_state_t        state_q, state_d;
  logic              we_q;
  lsu_size_t         size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              discard_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept;
  logic              go_done;
  logic              in_req;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] rdata_ext;

  assign accept = (state_q == IDLE) && lsu_req_i && !lsu_kill_i;

`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
  logic misaligned;
  logic mis_q;
  assign misaligned = ((lsu_size_t'(lsu_size_i) == LSU_HALF) && lsu_addr_i[0]) ||
                      ((lsu_size_t'(lsu_size_i) == LSU_WORD) && (lsu_addr_i[1:0] != 2'b00));
  assign go_done    = accept && misaligned;
  assign lsu_misalign_o = (state_q == DONE) && mis_q;
`else
  assign go_done = 1'b0;
`endif

  // Next-state: a trapped misaligned access jumps straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = go_done ? DONE : REQ;
      REQ: begin
        if (bus.data_gnt_i)  state_d = WAIT;
        else if (lsu_kill_i) state_d = IDLE;
      end
      WAIT: if (bus.data_rvalid_i) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, command latch, discard flag and load-data capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      size_q    <= LSU_BYTE;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      discard_q <= 1'b0;
      rdata_q   <= '0;
`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q      <= lsu_we_i;
        size_q    <= lsu_size_t'(lsu_size_i);
        uns_q     <= lsu_unsigned_i;
        addr_q    <= lsu_addr_i;
        wdata_q   <= lsu_wdata_i;
        discard_q <= 1'b0;
`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
        mis_q     <= misaligned;
        if (misaligned) rdata_q <= '0;
`endif
      end
      // A kill after the bus has taken the request cannot cancel it; just
      // remember to hide the completion from the core.
      if ((state_q == REQ && bus.data_gnt_i && lsu_kill_i) ||
          (state_q == WAIT && lsu_kill_i))
        discard_q <= 1'b1;
      if (state_q == WAIT && bus.data_rvalid_i && !we_q && !discard_q && !lsu_kill_i)
        rdata_q <= rdata_ext;
    end
  end

  miriscv_lsu_fmt #(.DATA_W(DATA_W)) u_fmt (
    .size      (size_q),
    .uns       (uns_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (bus.data_rdata_i),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  // Bus outputs are only non-zero while a request is presented.
  assign in_req           = (state_q == REQ);
  assign bus.data_req_o   = in_req;
  assign bus.data_we_o    = in_req & we_q;
  assign bus.data_be_o    = in_req ? be : 4'b0000;
  assign bus.data_addr_o  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus.data_wdata_o = in_req ? wdata_rep : '0;

  assign lsu_done_o  = (state_q == DONE) && !discard_q;
  assign lsu_rdata_o = rdata_q;
  assign lsu_stall_o = lsu_req_i & ~lsu_done_o;

endmodule

// File: tb/tb_miriscv_lsu_ctrl.sv
// Directed bench for miriscv_lsu_ctrl: reset, loads, stores, kill, reset
// mid-transaction, misaligned word and back-to-back commands.
module tb_miriscv_lsu_ctrl;
  import miriscv_comdecode_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [1:0]  lsu_size_i = 2'b00;
  logic        lsu_unsigned_i = 1'b0;
  logic [31:0] lsu_addr_i = '0;
  logic [31:0] lsu_wdata_i = '0;
  logic        lsu_kill_i = 1'b0;
  logic        lsu_stall_o;
  logic        lsu_done_o;
  logic [31:0] lsu_rdata_o;
`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
  logic        lsu_misalign_o;
`endif
  int checks = 0;
  int errors = 0;

  miriscv_lsu_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  miriscv_lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .lsu_req_i      (lsu_req_i),
    .lsu_we_i       (lsu_we_i),
    .lsu_size_i     (lsu_size_i),
    .lsu_unsigned_i (lsu_unsigned_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_kill_i     (lsu_kill_i),
    .lsu_stall_o    (lsu_stall_o),
    .lsu_done_o     (lsu_done_o),
    .lsu_rdata_o    (lsu_rdata_o),
`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
    .lsu_misalign_o (lsu_misalign_o),
`endif
    .bus            (bus)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic issue(input command_t c, input logic [31:0] a, input logic [31:0] wd);
    lsu_cmd_t d;
    d = lsu_cmd_decode(c);
    lsu_req_i      = 1'b1;
    lsu_we_i       = d.we;
    lsu_size_i     = d.size;
    lsu_unsigned_i = d.uns;
    lsu_addr_i     = a;
    lsu_wdata_i    = wd;
    #1;
  endtask

  task automatic idle_bus();
    bus.data_gnt_i    = 1'b0;
    bus.data_rvalid_i = 1'b0;
    bus.data_rdata_i  = '0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle_bus();
    tick(); tick();
    checks++; if (bus.data_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus.data_req_o); end
    checks++; if (bus.data_be_o !== 4'b0000) begin errors++; $display("FAIL rst_be got %b exp 0000", bus.data_be_o); end
    checks++; if (lsu_done_o !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", lsu_done_o); end
    checks++; if (lsu_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", lsu_rdata_o); end
    checks++; if (lsu_stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", lsu_stall_o); end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_load_byte();
    issue(LOAD_BYTE, 32'h0000_0103, 32'h0);
    checks++; if (lsu_stall_o !== 1'b1) begin errors++; $display("FAIL lb_stall got %b exp 1", lsu_stall_o); end
    tick();
    checks++; if (bus.data_req_o !== 1'b1) begin errors++; $display("FAIL lb_req got %b exp 1", bus.data_req_o); end
    checks++; if (bus.data_addr_o !== 32'h0000_0100) begin errors++; $display("FAIL lb_addr got %h exp 00000100", bus.data_addr_o); end
    checks++; if (bus.data_be_o !== 4'b1000) begin errors++; $display("FAIL lb_be got %b exp 1000", bus.data_be_o); end
    checks++; if (bus.data_we_o !== 1'b0) begin errors++; $display("FAIL lb_we got %b exp 0", bus.data_we_o); end
    bus.data_gnt_i = 1'b1;
    tick();
    bus.data_gnt_i = 1'b0;
    checks++; if (bus.data_req_o !== 1'b0) begin errors++; $display("FAIL lb_req_wait got %b exp 0", bus.data_req_o); end
    bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'h80FF_1234;
    tick();
    idle_bus();
    checks++; if (lsu_done_o !== 1'b1) begin errors++; $display("FAIL lb_done got %b exp 1", lsu_done_o); end
    checks++; if (lsu_rdata_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata got %h exp ffffff80", lsu_rdata_o); end
    checks++; if (lsu_stall_o !== 1'b0) begin errors++; $display("FAIL lb_stall_done got %b exp 0", lsu_stall_o); end
    lsu_req_i = 1'b0;
    tick();
    checks++; if (lsu_done_o !== 1'b0) begin errors++; $display("FAIL lb_done_pulse got %b exp 0", lsu_done_o); end
    checks++; if (lsu_rdata_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata_hold got %h exp ffffff80", lsu_rdata_o); end
  endtask

  task automatic test_load_half_unsigned();
    issue(LOAD_HALF_UNSIGN, 32'h0000_0202, 32'h0);
    tick();
    checks++; if (bus.data_be_o !== 4'b1100) begin errors++; $display("FAIL lhu_be got %b exp 1100", bus.data_be_o); end
    checks++; if (bus.data_addr_o !== 32'h0000_0200) begin errors++; $display("FAIL lhu_addr got %h exp 00000200", bus.data_addr_o); end
    bus.data_gnt_i = 1'b1;
    tick();
    bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'hBEEF_0000;
    tick();
    idle_bus();
    checks++; if (lsu_done_o !== 1'b1) begin errors++; $display("FAIL lhu_done got %b exp 1", lsu_done_o); end
    checks++; if (lsu_rdata_o !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_rdata got %h exp 0000beef", lsu_rdata_o); end
    lsu_req_i = 1'b0;
    tick();
  endtask

  task automatic test_store_byte();
    issue(STORE_BYTE, 32'h0000_0301, 32'h0000_00A5);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.data_gnt_i = 1'b1;
      checks++; if (bus.data_req_o !== 1'b1) begin errors++; $display("FAIL sb_req[%0d] got %b exp 1", i, bus.data_req_o); end
      checks++; if (bus.data_wdata_o !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata[%0d] got %h exp a5a5a5a5", i, bus.data_wdata_o); end
      checks++; if (bus.data_be_o !== 4'b0010) begin errors++; $display("FAIL sb_be[%0d] got %b exp 0010", i, bus.data_be_o); end
      checks++; if (bus.data_we_o !== 1'b1) begin errors++; $display("FAIL sb_we[%0d] got %b exp 1", i, bus.data_we_o); end
      checks++; if (bus.data_addr_o !== 32'h0000_0300) begin errors++; $display("FAIL sb_addr[%0d] got %h exp 00000300", i, bus.data_addr_o); end
      tick();
    end
    bus.data_gnt_i = 1'b0;
    checks++; if (lsu_done_o !== 1'b0) begin errors++; $display("FAIL sb_early_done got %b exp 0", lsu_done_o); end
    bus.data_rvalid_i = 1'b1;
    tick();
    idle_bus();
    checks++; if (lsu_done_o !== 1'b1) begin errors++; $display("FAIL sb_done got %b exp 1", lsu_done_o); end
    lsu_req_i = 1'b0;
    tick();
  endtask

  task automatic test_kill();
    // kill while requesting, before grant
    issue(LOAD_WORD, 32'h0000_0600, 32'h0);
    tick();
    lsu_kill_i = 1'b1; lsu_req_i = 1'b0;
    tick();
    lsu_kill_i = 1'b0;
    checks++; if (bus.data_req_o !== 1'b0) begin errors++; $display("FAIL kreq_req got %b exp 0", bus.data_req_o); end
    checks++; if (lsu_done_o !== 1'b0) begin errors++; $display("FAIL kreq_done got %b exp 0", lsu_done_o); end
    bus.data_gnt_i = 1'b1;  // stray grant in IDLE is ignored
    tick();
    bus.data_gnt_i = 1'b0;
    checks++; if (lsu_done_o !== 1'b0 || bus.data_req_o !== 1'b0) begin errors++; $display("FAIL kreq_idle got done=%b req=%b exp 0 0", lsu_done_o, bus.data_req_o); end
    tick();
    // kill while waiting for the response
    issue(LOAD_WORD, 32'h0000_0700, 32'h0);
    tick();
    bus.data_gnt_i = 1'b1;
    tick();
    bus.data_gnt_i = 1'b0; lsu_kill_i = 1'b1; lsu_req_i = 1'b0;
    tick();
    lsu_kill_i = 1'b0; bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'h1111_2222;
    tick();
    idle_bus();
    checks++; if (lsu_done_o !== 1'b0) begin errors++; $display("FAIL kwait_done got %b exp 0", lsu_done_o); end
    checks++; if (lsu_rdata_o === 32'h1111_2222) begin errors++; $display("FAIL kwait_rdata got %h exp not 11112222", lsu_rdata_o); end
    tick();
    checks++; if (lsu_done_o !== 1'b0) begin errors++; $display("FAIL kwait_after got %b exp 0", lsu_done_o); end
  endtask

  task automatic test_reset_mid();
    issue(LOAD_BYTE, 32'h0000_0800, 32'h0);
    tick();
    bus.data_gnt_i = 1'b1;
    tick();
    bus.data_gnt_i = 1'b0; rst_i = 1'b1;
    tick();
    rst_i = 1'b0; lsu_req_i = 1'b0;
    checks++; if (bus.data_req_o !== 1'b0 || bus.data_be_o !== 4'b0 || bus.data_addr_o !== 32'h0)
      begin errors++; $display("FAIL rmid_bus got req=%b be=%b addr=%h exp 0 0 0", bus.data_req_o, bus.data_be_o, bus.data_addr_o); end
    checks++; if (lsu_done_o !== 1'b0 || lsu_rdata_o !== 32'h0) begin errors++; $display("FAIL rmid_lsu got done=%b rdata=%h exp 0 0", lsu_done_o, lsu_rdata_o); end
    bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'hDEAD_BEEF;
    tick();
    idle_bus();
    checks++; if (lsu_done_o !== 1'b0) begin errors++; $display("FAIL rmid_late1 got %b exp 0", lsu_done_o); end
    tick();
    checks++; if (lsu_done_o !== 1'b0) begin errors++; $display("FAIL rmid_late2 got %b exp 0", lsu_done_o); end
  endtask

  task automatic test_load_word_misaligned();
    issue(LOAD_WORD, 32'h0000_0402, 32'h0);
    tick();
`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
    checks++; if (bus.data_req_o !== 1'b0) begin errors++; $display("FAIL lwm_req got %b exp 0", bus.data_req_o); end
    checks++; if (lsu_done_o !== 1'b1 || lsu_misalign_o !== 1'b1) begin errors++; $display("FAIL lwm_pulse got done=%b mis=%b exp 1 1", lsu_done_o, lsu_misalign_o); end
    checks++; if (lsu_rdata_o !== 32'h0) begin errors++; $display("FAIL lwm_rdata got %h exp 0", lsu_rdata_o); end
    lsu_req_i = 1'b0;
    tick();
    checks++; if (lsu_done_o !== 1'b0 || lsu_misalign_o !== 1'b0) begin errors++; $display("FAIL lwm_after got done=%b mis=%b exp 0 0", lsu_done_o, lsu_misalign_o); end
`else
    checks++; if (bus.data_be_o !== 4'b1111) begin errors++; $display("FAIL lwm_be got %b exp 1111", bus.data_be_o); end
    checks++; if (bus.data_addr_o !== 32'h0000_0400) begin errors++; $display("FAIL lwm_addr got %h exp 00000400", bus.data_addr_o); end
    bus.data_gnt_i = 1'b1;
    tick();
    bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'h1234_5678;
    tick();
    idle_bus();
    checks++; if (lsu_done_o !== 1'b1) begin errors++; $display("FAIL lwm_done got %b exp 1", lsu_done_o); end
    checks++; if (lsu_rdata_o !== 32'h1234_5678) begin errors++; $display("FAIL lwm_rdata got %h exp 12345678", lsu_rdata_o); end
    lsu_req_i = 1'b0;
    tick();
`endif
  endtask

  task automatic test_back_to_back();
    issue(STORE_HALF, 32'h0000_0502, 32'h0000_CAFE);
    tick();
    checks++; if (bus.data_wdata_o !== 32'hCAFE_CAFE) begin errors++; $display("FAIL b2b_sh_wdata got %h exp cafecafe", bus.data_wdata_o); end
    checks++; if (bus.data_be_o !== 4'b1100) begin errors++; $display("FAIL b2b_sh_be got %b exp 1100", bus.data_be_o); end
    bus.data_gnt_i = 1'b1;
    tick();
    bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b1;
    tick();
    idle_bus();
    checks++; if (lsu_done_o !== 1'b1) begin errors++; $display("FAIL b2b_sh_done got %b exp 1", lsu_done_o); end
    issue(LOAD_HALF, 32'h0000_0500, 32'h0);  // request stays high
    tick();
    checks++; if (bus.data_req_o !== 1'b0 || lsu_done_o !== 1'b0) begin errors++; $display("FAIL b2b_gap got req=%b done=%b exp 0 0", bus.data_req_o, lsu_done_o); end
    tick();
    checks++; if (bus.data_be_o !== 4'b0011 || bus.data_we_o !== 1'b0) begin errors++; $display("FAIL b2b_lh_be got be=%b we=%b exp 0011 0", bus.data_be_o, bus.data_we_o); end
    bus.data_gnt_i = 1'b1;
    tick();
    bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'h1234_8001;
    tick();
    idle_bus();
    checks++; if (lsu_done_o !== 1'b1) begin errors++; $display("FAIL b2b_lh_done got %b exp 1", lsu_done_o); end
    checks++; if (lsu_rdata_o !== 32'hFFFF_8001) begin errors++; $display("FAIL b2b_lh_rdata got %h exp ffff8001", lsu_rdata_o); end
    lsu_req_i = 1'b0;
    tick();
  endtask

  initial begin
    idle_bus();
    test_reset();
    test_load_byte();
    test_load_half_unsigned();
    test_store_byte();
    test_kill();
    test_reset_mid();
    test_load_word_misaligned();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
